// File: rtl/keypad_pin_entry.sv
// 4-digit BCD PIN checker with fail counting, timed lockout and entry timeout; enter -> unlock/bad_pin in 2 cycles.
// No backpressure: keys arriving while a check, grant, deny or lockout is in progress are dropped.
module keypad_pin_entry #(
    parameter logic [15:0] DEFAULT_PIN         = 16'h1234,
    parameter int          MAX_FAILS           = 3,
    parameter int          LOCKOUT_CYCLES      = 500_000_000,
    parameter int          ENTRY_TIMEOUT       = 250_000_000,
    parameter int          UNLOCK_PULSE_CYCLES = 4
) (
    input  logic        FPGA_CLK1_50,
    input  logic        reset_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        pin_load,
    input  logic [15:0] pin_value,
    output logic        unlock_signal,
    output logic        bad_pin,
    output logic        lockout,
    output logic [2:0]  digit_count
);

    localparam int MAX_AB  = (LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > UNLOCK_PULSE_CYCLES) ? MAX_AB : UNLOCK_PULSE_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] ENTRY_LAST = TW'(ENTRY_TIMEOUT - 1);
    localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(UNLOCK_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [2:0]    MAX_F      = 3'(MAX_FAILS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_GRANT,
        ST_DENY,
        ST_LOCKOUT
    } state_t;

    state_t         state_q;
    logic [15:0]    entry_q;
    logic [15:0]    pin_q;
    logic [2:0]     cnt_q;
    logic           overlong_q;
    logic [2:0]     fail_q;
    logic [TW-1:0]  timer_q;
    logic           unlock_q;
    logic           bad_q;
    logic           lock_q;

    logic key_digit;
    logic key_clear;
    logic key_enter;
    logic pin_match;
    logic [2:0] fail_next;

    assign key_digit = key_valid && (key_code <= 4'd9);
    assign key_clear = key_valid && (key_code == 4'hA);
    assign key_enter = key_valid && (key_code == 4'hB);
    assign pin_match = (cnt_q == 3'd4) && !overlong_q && (entry_q == pin_q);
    assign fail_next = fail_q + 3'd1;

    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            entry_q    <= '0;
            pin_q      <= DEFAULT_PIN;
            cnt_q      <= '0;
            overlong_q <= 1'b0;
            fail_q     <= '0;
            timer_q    <= '0;
            unlock_q   <= 1'b0;
            bad_q      <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            // The stored PIN updates in any state; CHECK still sees the old value this cycle.
            if (pin_load) begin
                pin_q <= pin_value;
            end

            unique case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    if (pin_load || key_clear) begin
                        entry_q    <= '0;
                        cnt_q      <= '0;
                        overlong_q <= 1'b0;
                    end else if (key_digit) begin
                        entry_q <= {12'h000, key_code};
                        cnt_q   <= 3'd1;
                        state_q <= ST_ENTRY;
                    end
                end

                ST_ENTRY: begin
                    if (pin_load || key_clear) begin
                        entry_q    <= '0;
                        cnt_q      <= '0;
                        overlong_q <= 1'b0;
                        timer_q    <= '0;
                        state_q    <= ST_IDLE;
                    end else if (key_digit) begin
                        timer_q <= '0;
                        if (cnt_q == 3'd4) begin
                            overlong_q <= 1'b1;
                        end else begin
                            entry_q <= {entry_q[11:0], key_code};
                            cnt_q   <= cnt_q + 3'd1;
                        end
                    end else if (key_enter) begin
                        timer_q <= '0;
                        state_q <= ST_CHECK;
                    end else if (timer_q == ENTRY_LAST) begin
                        entry_q    <= '0;
                        cnt_q      <= '0;
                        overlong_q <= 1'b0;
                        timer_q    <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TIMER_ONE;
                    end
                end

                ST_CHECK: begin
                    entry_q    <= '0;
                    cnt_q      <= '0;
                    overlong_q <= 1'b0;
                    timer_q    <= '0;
                    if (pin_match) begin
                        unlock_q <= 1'b1;
                        state_q  <= ST_GRANT;
                    end else begin
                        bad_q   <= 1'b1;
                        state_q <= ST_DENY;
                    end
                end

                ST_GRANT: begin
                    fail_q <= '0;
                    if (timer_q == PULSE_LAST) begin
                        unlock_q <= 1'b0;
                        timer_q  <= '0;
                        state_q  <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TIMER_ONE;
                    end
                end

                ST_DENY: begin
                    bad_q   <= 1'b0;
                    timer_q <= '0;
                    if (fail_next == MAX_F) begin
                        fail_q  <= fail_next;
                        lock_q  <= 1'b1;
                        state_q <= ST_LOCKOUT;
                    end else begin
                        fail_q  <= fail_next;
                        state_q <= ST_IDLE;
                    end
                end

                ST_LOCKOUT: begin
                    if (timer_q == LOCK_LAST) begin
                        lock_q  <= 1'b0;
                        fail_q  <= '0;
                        timer_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TIMER_ONE;
                    end
                end

                default: begin
                    state_q  <= ST_IDLE;
                    unlock_q <= 1'b0;
                    bad_q    <= 1'b0;
                    lock_q   <= 1'b0;
                    timer_q  <= '0;
                end
            endcase
        end
    end

    assign unlock_signal = unlock_q;
    assign bad_pin       = bad_q;
    assign lockout       = lock_q;
    assign digit_count   = cnt_q;

    a_fail_bounded: assert property (@(posedge FPGA_CLK1_50) disable iff (!reset_n) fail_q <= MAX_F);
    a_count_bounded: assert property (@(posedge FPGA_CLK1_50) disable iff (!reset_n) cnt_q <= 3'd4);
    a_outputs_exclusive: assert property (@(posedge FPGA_CLK1_50) disable iff (!reset_n)
        !(unlock_q && bad_q) && !(unlock_q && lock_q));

endmodule

// File: tb/tb_keypad_pin_entry.sv
// Bench for keypad_pin_entry: table vectors, directed corner sequences and random keys vs. an event-time model.
module tb_keypad_pin_entry;

    localparam int P  = 4;
    localparam int L  = 20;
    localparam int T  = 10;
    localparam int MF = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        pin_load;
    logic [15:0] pin_value;
    logic        unlock_signal;
    logic        bad_pin;
    logic        lockout;
    logic [2:0]  digit_count;

    always #5 clk = ~clk;

    keypad_pin_entry #(
        .DEFAULT_PIN        (16'h1234),
        .MAX_FAILS          (MF),
        .LOCKOUT_CYCLES     (L),
        .ENTRY_TIMEOUT      (T),
        .UNLOCK_PULSE_CYCLES(P)
    ) dut (
        .FPGA_CLK1_50 (clk),
        .reset_n      (reset_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .pin_load     (pin_load),
        .pin_value    (pin_value),
        .unlock_signal(unlock_signal),
        .bad_pin      (bad_pin),
        .lockout      (lockout),
        .digit_count  (digit_count)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int obs_unl = 0, obs_bad = 0, obs_lk = 0;

    // Reference model: digits typed so far plus absolute cycle windows of every output event.
    int          q[$];
    logic [15:0] m_pin;
    int          m_fails, busy_until, last_key, show_until, shown_cnt;
    int          unl_lo, unl_hi, bad_at, lk_lo, lk_hi;

    function automatic void model_reset();
        q.delete();
        m_pin = 16'h1234;
        m_fails = 0; busy_until = -10; last_key = -10;
        show_until = -10; shown_cnt = 0;
        unl_lo = -10; unl_hi = -10; bad_at = -10; lk_lo = -10; lk_hi = -10;
    endfunction

    function automatic void model_enter(input int n);
        int v = 0;
        bit ok;
        foreach (q[i]) v = v * 16 + q[i];
        ok = (q.size() == 4) && (v == int'(m_pin));
        shown_cnt = (q.size() > 4) ? 4 : q.size();
        show_until = n + 1;
        q.delete();
        if (ok) begin
            unl_lo = n + 2; unl_hi = n + 1 + P; m_fails = 0; busy_until = n + 1 + P;
        end else begin
            bad_at = n + 2;
            m_fails++;
            if (m_fails == MF) begin
                lk_lo = n + 3; lk_hi = n + 2 + L; busy_until = n + 2 + L; m_fails = 0;
            end else begin
                busy_until = n + 2;
            end
        end
    endfunction

    function automatic void model_step(input logic kv, input logic [3:0] kc, input logic pl, input logic [15:0] pv);
        int n = cyc;
        if (n <= busy_until) begin
            if (pl) m_pin = pv;
        end else if (pl) begin
            m_pin = pv; q.delete();
        end else if (kv && kc <= 4'd9) begin
            q.push_back(int'(kc)); last_key = n;
        end else if (kv && kc == 4'hA) begin
            q.delete();
        end else if (kv && kc == 4'hB && q.size() > 0) begin
            model_enter(n);
        end else if (q.size() > 0 && n - last_key == T) begin
            q.delete();
        end
    endfunction

    task automatic check_model();
        int m = cyc;
        logic e_unl, e_bad, e_lk;
        logic [2:0] e_cnt;
        e_unl = (m >= unl_lo) && (m <= unl_hi);
        e_bad = (m == bad_at);
        e_lk  = (m >= lk_lo) && (m <= lk_hi);
        e_cnt = (m <= show_until) ? 3'(shown_cnt) : 3'((q.size() > 4) ? 4 : q.size());
        vectors++;
        if ({unlock_signal, bad_pin, lockout, digit_count} !== {e_unl, e_bad, e_lk, e_cnt}) begin
            miscompares++;
            $display("FAIL model cyc=%0d got unl=%b bad=%b lk=%b cnt=%0d want unl=%b bad=%b lk=%b cnt=%0d",
                     m, unlock_signal, bad_pin, lockout, digit_count, e_unl, e_bad, e_lk, e_cnt);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic kv, input logic [3:0] kc, input logic pl, input logic [15:0] pv);
        key_valid = kv; key_code = kc; pin_load = pl; pin_value = pv;
        @(posedge clk);
        model_step(kv, kc, pl, pv);
        cyc++;
        #1;
        check_model();
        if (unlock_signal) obs_unl++;
        if (bad_pin) obs_bad++;
        if (lockout) obs_lk++;
        key_valid = 1'b0; key_code = 4'h0; pin_load = 1'b0;
    endtask

    task automatic key(input int c);
        step(1'b1, 4'(c), 1'b0, 16'h0000);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 4'h0, 1'b0, 16'h0000);
    endtask

    task automatic code4(input logic [15:0] p);
        key(int'(p[15:12])); key(int'(p[11:8])); key(int'(p[7:4])); key(int'(p[3:0])); key(11);
    endtask

    task automatic clr_obs();
        obs_unl = 0; obs_bad = 0; obs_lk = 0;
    endtask

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic       unl;
        logic       bad;
        logic       lk;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 3'd1};
        tbl[1]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 3'd2};
        tbl[2]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 3'd3};
        tbl[3]  = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 3'd4};
        tbl[4]  = '{1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 3'd4};
        tbl[5]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[6]  = '{1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[7]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[8]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[9]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[10] = '{1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[11] = '{1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 3'd1};
        tbl[12] = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 3'd0};

        reset_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; pin_load = 1'b0; pin_value = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_unlock", int'(unlock_signal), 0);
        check_val("reset_bad", int'(bad_pin), 0);
        check_val("reset_lockout", int'(lockout), 0);
        check_val("reset_count", int'(digit_count), 0);
        reset_n = 1'b1;

        // Correct PIN timing, ignored keys during grant, ignored codes, clear.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].kv, tbl[i].kc, 1'b0, 16'h0000);
            vectors++;
            if ({unlock_signal, bad_pin, lockout, digit_count} !== {tbl[i].unl, tbl[i].bad, tbl[i].lk, tbl[i].cnt}) begin
                miscompares++;
                $display("FAIL table[%0d] got %b%b%b/%0d want %b%b%b/%0d", i, unlock_signal, bad_pin, lockout,
                         digit_count, tbl[i].unl, tbl[i].bad, tbl[i].lk, tbl[i].cnt);
            end
        end

        // Wrong and short entries, then a grant resets the fail count.
        clr_obs();
        code4(16'h1235); idle(4);
        key(1); key(2); key(11); idle(4);
        check_val("wrong_short_bad", obs_bad, 2);
        check_val("wrong_short_unlock", obs_unl, 0);
        clr_obs();
        code4(16'h1234); idle(6);
        check_val("regrant_unlock", obs_unl, P);
        clr_obs();
        code4(16'h9999); idle(4);
        key(9); key(11); idle(4);
        check_val("after_grant_bad", obs_bad, 2);
        check_val("after_grant_nolock", obs_lk, 0);

        // Lockout with a correct PIN keyed while locked.
        code4(16'h1234); idle(6);
        clr_obs();
        key(5); key(11); idle(4);
        key(5); key(11); idle(4);
        key(5); key(11); idle(2);
        code4(16'h1234); idle(25);
        check_val("lockout_cycles", obs_lk, L);
        check_val("lockout_bad", obs_bad, 3);
        check_val("lockout_unlock", obs_unl, 0);
        clr_obs();
        code4(16'h1234); idle(6);
        check_val("post_lockout_unlock", obs_unl, P);

        // Overlong entry, then a cleared partial entry.
        clr_obs();
        key(1); key(2); key(3); key(4); key(5); key(11); idle(4);
        check_val("overlong_bad", obs_bad, 1);
        key(9); key(9); key(10);
        code4(16'h1234); idle(6);
        check_val("clear_then_unlock", obs_unl, P);

        // Inactivity timeout.
        clr_obs();
        key(1); key(2); idle(T);
        check_val("timeout_count", int'(digit_count), 0);
        check_val("timeout_nobad", obs_bad, 0);
        key(3); key(4); key(11); idle(4);
        check_val("timeout_short_bad", obs_bad, 1);

        // PIN load during entry, key dropped with simultaneous pin_load, reset mid-pulse.
        clr_obs();
        key(1); key(2);
        step(1'b0, 4'h0, 1'b1, 16'h0420);
        check_val("pin_load_clears", int'(digit_count), 0);
        step(1'b1, 4'h5, 1'b1, 16'h0420);
        check_val("pin_load_wins", int'(digit_count), 0);
        code4(16'h0420); idle(6);
        check_val("new_pin_unlock", obs_unl, P);
        code4(16'h1234); idle(4);
        check_val("old_pin_bad", obs_bad, 1);
        code4(16'h0420); idle(2);
        check_val("pulse_before_reset", int'(unlock_signal), 1);
        #2 reset_n = 1'b0;
        #1;
        check_val("reset_drops_unlock", int'(unlock_signal), 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        model_reset();
        clr_obs();
        code4(16'h1234); idle(6);
        check_val("default_pin_restored", obs_unl, P);

        // Random keys against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 39) == 0) begin
                idle(T + 2);
            end else if (r < 10) begin
                key(11);
            end else if (r < 13) begin
                key(10);
            end else if (r < 16) begin
                key($urandom_range(12, 15));
            end else if (r < 55) begin
                if (q.size() < 4 && $urandom_range(0, 9) < 7)
                    key(int'((m_pin >> (4 * (3 - q.size()))) & 16'h000F));
                else
                    key($urandom_range(0, 9));
            end else if (r == 55) begin
                logic [15:0] pv;
                pv = ($urandom_range(0, 1) == 0) ? 16'h1234 :
                     {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                step(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 11)), 1'b1, pv);
            end else begin
                idle(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
